fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction fetch unit with a prefetch queue. Issues sequential
//  fetch requests to a variable-latency, in-order instruction memory and buffers
//  returned words with their PC in a FIFO. Presents each instruction to decode via
//  valid/ready, with an ARM condition-code pass flag evaluated against live NZCV.
//  Supports branch redirect: flushes the queue and discards in-flight responses.
// PARAMETERS
//  XLEN      32  instruction/data width; cond field is [XLEN-1:XLEN-4]
//  ADDR_W    32  PC width; PC advances by XLEN/8 per instruction
//  DEPTH     4   prefetch FIFO entries (power of 2, >=2); also max outstanding requests
//  RESET_PC  0   fetch address after reset
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       synchronous reset, active-low (0 = reset)
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  fetch byte address
//  imem_rsp_valid  in   1       response word valid (in request order, no backpressure)
//  imem_rsp_data   in   XLEN    response word
//  redirect_valid  in   1       branch taken: restart fetch at redirect_pc
//  redirect_pc     in   ADDR_W  redirect target (word-aligned)
//  nzcv            in   4       flags {N,Z,C,V}
//  ir_valid        out  1       head instruction valid
//  ir_ready        in   1       decode consumes head
//  ir              out  XLEN    head instruction
//  ir_pc           out  ADDR_W  PC of head instruction
//  cond_pass       out  1       head condition satisfied under current nzcv
// BEHAVIOUR
//  Reset (rst=0 at edge): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty,
//   outstanding=0, discard=0. During reset and the cycle after: imem_req_valid=0,
//   ir_valid=0. Responses arriving while rst=0 are ignored.
//  Issue: imem_req_valid = !redirect_valid && (count+outstanding < DEPTH).
//   imem_req_addr = fetch_pc. Handshake (valid&ready): fetch_pc += XLEN/8,
//   outstanding+1. Addr/valid stable while stalled unless redirect.
//  Response: if discard>0, drop word, discard-1, outstanding-1. Else push
//   {rsp_pc, data}, rsp_pc += XLEN/8, outstanding-1. Credit rule guarantees no
//   overflow; push into full FIFO is an assertion failure.
//  Issue and response same cycle: outstanding unchanged.
//  Output: ir_valid = !empty && !redirect_valid; ir/ir_pc from head, registered
//   storage, zero added latency. Pop on ir_valid&ir_ready. Push+pop same cycle
//   legal at any occupancy, including full. Min latency request-accept to
//   ir_valid: memory latency + 1 cycle.
//  Redirect (highest priority after reset): FIFO cleared, fetch_pc=rsp_pc=
//   redirect_pc, discard = outstanding after this cycle's response (i.e. all
//   requests still in flight), no request issued, no pop. Back-to-back redirects:
//   discard accumulates correctly; last target wins.
//  cond_pass (combinational on head cond field and nzcv): EQ Z; NE !Z; CS C; CC !C;
//   MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V);
//   LE Z|(N!=V); AL 1; 4'hF 1. Unqualified by ir_valid; decode qualifies.
//  Counters: count, outstanding, discard each $clog2(DEPTH+1) bits; FIFO pointers
//   wrap modulo DEPTH; PC arithmetic wraps modulo 2^ADDR_W.
// STRUCTURE
//  Package fetch_pkg: cond code localparams (EQ..AL, NV=4'hF), flag bit indices
//   (N=3,Z=2,C=1,V=0).
//  Sub-module cond_eval (pure combinational: cond[3:0], nzcv[3:0] -> pass);
//   shared later with execute-stage predication. FIFO kept inline.
// TESTING
//  1 Reset release, 1-cycle memory, ir_ready=1 -> addrs 0,4,8..; ir_pc 0,4,8 in
//    order, one instruction per cycle after fill.
//  2 ir_ready=0, DEPTH=4 -> exactly 4 requests issued, imem_req_valid drops, FIFO
//    full; raise ir_ready -> all 4 delivered, no loss or duplicate.
//  3 3-cycle memory, 2 requests in flight, redirect_pc=0x40 -> 2 stale responses
//    dropped; next ir_pc=0x40, ir = mem[0x40].
//  4 head 0x0xxxxxxx with nzcv=4'b0100 -> cond_pass=1; head 0x1... -> 0; head
//    0xC... with nzcv=4'b1001 -> 1, nzcv=4'b1101 -> 0; head 0xF... -> 1.
//  5 rst=0 with FIFO full and 2 in flight -> next cycle ir_valid=0,
//    imem_req_valid=0; after release fetch restarts at RESET_PC, late responses not seen.
//  6 imem_req_ready=0 for 5 cycles -> imem_req_addr and valid stable, fetch_pc unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/execute definitions: ARM condition codes and NZCV flag positions.
package fetch_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check against NZCV; shared with execute predication.
module cond_eval
    import fetch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    always_comb begin
        flag_n = nzcv[FLAG_N];
        flag_z = nzcv[FLAG_Z];
        flag_c = nzcv[FLAG_C];
        flag_v = nzcv[FLAG_V];
        pass   = 1'b1;
        case (cond)
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction fetch with credit-limited prefetch FIFO and branch redirect.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [3:0]        nzcv,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [XLEN-1:0]   ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              cond_pass
);

    localparam int unsigned       CW      = $clog2(DEPTH + 1);
    localparam int unsigned       PW      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(XLEN / 8);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              active_q, active_d;
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [XLEN-1:0]   data_d [DEPTH];
    logic [ADDR_W-1:0] pcs_q  [DEPTH];
    logic [ADDR_W-1:0] pcs_d  [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic rsp_drop;
    logic push;
    logic pop;

    // Outstanding requests already reserve FIFO slots, so a response can never overflow.
    always_comb begin
        credit_ok      = (({1'b0, count_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH));
        imem_req_valid = rst && active_q && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        ir_valid       = rst && active_q && (count_q != '0) && !redirect_valid;
        ir             = data_q[rd_ptr_q];
        ir_pc          = pcs_q[rd_ptr_q];
        pop            = ir_valid && ir_ready;
        rsp_drop       = imem_rsp_valid && (discard_q != '0);
        push           = rst && imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        active_d      = 1'b1;
        data_d        = data_q;
        pcs_d         = pcs_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                data_d[wr_ptr_q] = imem_rsp_data;
                pcs_d[wr_ptr_q]  = rsp_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                rsp_pc_d         = rsp_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            active_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            active_q      <= active_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        pcs_q  <= pcs_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && !pop && (count_q == CW'(DEPTH))));
            assert (!(imem_rsp_valid && (outstanding_q == '0)));
        end
    end

    cond_eval u_cond_eval (
        .cond (ir[XLEN-1 -: 4]),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

endmodule
